// File: rtl/product_normalizer_if.sv
// Handshake and data bundle between the multiplier back end and the normalizer.
interface product_normalizer_if;
   logic        iValid;
   logic        oReady;
   logic [14:0] iMantP;
   logic [4:0]  iExpP;
   logic        oValid;
   logic        iReady;
   logic [9:0]  oMant;
   logic [4:0]  oExp;
   logic        oOvf;
   logic        oUnf;

   // Producer/consumer side (drives the product, accepts the result)
   modport master (
      output iValid, iMantP, iExpP, iReady,
      input  oReady, oValid, oMant, oExp, oOvf, oUnf
   );

   // Normalizer side
   modport slave (
      input  iValid, iMantP, iExpP, iReady,
      output oReady, oValid, oMant, oExp, oOvf, oUnf
   );
endinterface

// File: rtl/product_normalizer.sv
// Normalizes a 15-bit product mantissa to a 10-bit mantissa with its MSB set,
// shifting one bit per cycle, then rounds half up and range-checks the exponent.
module product_normalizer (
   input  logic                clkNorm,
   input  logic                iReset_n,
   product_normalizer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   state_t             state_q, state_d;
   logic [14:0]        w_q, w_d;
   logic signed [6:0]  x_q, x_d;
   logic [9:0]         mant_q, mant_d;
   logic [4:0]         exp_q, exp_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               ready_q, ready_d;
   logic               valid_q, valid_d;

   logic [10:0]        t;
   logic signed [6:0]  eo;
   logic [9:0]         rnd_mant;

   // Rounding datapath: top 10 bits plus the next bit, exponent kept 7-bit
   // signed so the range check sees the true value before truncation.
   always_comb begin
      t        = {1'b0, w_q[14:5]} + {10'd0, w_q[4]};
      eo       = x_q + 7'sd5;
      rnd_mant = t[9:0];
      if (t[10]) begin
         rnd_mant = 10'h200;
         eo       = x_q + 7'sd6;
      end
   end

   // Next-state and next-output logic for the shift/round sequencer
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      x_d     = x_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.iValid) begin
               w_d     = bus.iMantP;
               x_d     = {{2{bus.iExpP[4]}}, bus.iExpP};
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (w_q[14] || (w_q == 15'd0)) begin
               state_d = ROUND;
            end else begin
               w_d = {w_q[13:0], 1'b0};
               x_d = x_q - 7'sd1;
            end
         end
         ROUND: begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            if (w_q == 15'd0) begin
               mant_d = 10'd0;
               exp_d  = 5'd0;
            end else if (eo > 7'sd15) begin
               mant_d = 10'h3FF;
               exp_d  = 5'b01111;
               ovf_d  = 1'b1;
            end else if (eo < -7'sd16) begin
               mant_d = 10'd0;
               exp_d  = 5'd0;
               unf_d  = 1'b1;
            end else begin
               mant_d = rnd_mant;
               exp_d  = eo[4:0];
            end
            state_d = DONE;
         end
         DONE: begin
            if (bus.iReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      valid_d = (state_d == DONE);
   end

   // State and registered outputs; reset discards any word in flight
   always_ff @(posedge clkNorm or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q <= IDLE;
         w_q     <= 15'd0;
         x_q     <= 7'sd0;
         mant_q  <= 10'd0;
         exp_q   <= 5'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         x_q     <= x_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign bus.oReady = ready_q;
   assign bus.oValid = valid_q;
   assign bus.oMant  = mant_q;
   assign bus.oExp   = exp_q;
   assign bus.oOvf   = ovf_q;
   assign bus.oUnf   = unf_q;

endmodule

// File: tb/tb_product_normalizer.sv
// Randomized scoreboard bench for product_normalizer.
module tb_product_normalizer;

   logic clkNorm = 1'b0;
   logic iReset_n;
   product_normalizer_if bus();

   product_normalizer dut (
      .clkNorm  (clkNorm),
      .iReset_n (iReset_n),
      .bus      (bus)
   );

   always #5 clkNorm = ~clkNorm;

   typedef struct {
      int mant;
      int exp;
      int ovf;
      int unf;
      int due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   ncmp = 0;
   int   nerr = 0;
   bit   bp_force = 1'b0;

   always @(posedge clkNorm) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      ncmp++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   // Reference: value = M * 2^E, re-expressed as t * 2^e with t in [512,1023]
   function automatic exp_t model(input logic [14:0] m, input logic [4:0] e, input int acc);
      exp_t r;
      int   p, ee, t;
      logic [4:0] ev;
      ee = int'($signed(e));
      if (m == 15'd0) begin
         r = '{0, 0, 0, 0, acc + 2};
         return r;
      end
      p = 14;
      while (!m[p]) p--;
      if (p > 9) t = (int'(m) + (1 << (p - 10))) >> (p - 9);
      else       t = int'(m) << (9 - p);
      ee = ee + p - 9;
      if (t == 1024) begin
         t  = 512;
         ee = ee + 1;
      end
      r.due = acc + (14 - p) + 2;
      if (ee > 15)       begin r.mant = 'h3FF; r.exp = 15; r.ovf = 1; r.unf = 0; end
      else if (ee < -16) begin r.mant = 0;     r.exp = 0;  r.ovf = 0; r.unf = 1; end
      else begin
         ev = ee[4:0];
         r.mant = t; r.exp = int'(ev); r.ovf = 0; r.unf = 0;
      end
      return r;
   endfunction

   // Downstream ready: random unless a test forces backpressure
   initial begin
      bus.iReady = 1'b0;
      forever begin
         @(negedge clkNorm);
         bus.iReady = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pop on each new result, then check it stays stable while held
   initial begin
      exp_t cur;
      bit   prev = 1'b0;
      bit   have = 1'b0;
      forever begin
         @(negedge clkNorm);
         if (bus.oValid && !prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 1, 0);
               have = 1'b0;
            end else begin
               cur  = sb.pop_front();
               have = 1'b1;
               chk("latency", cyc, cur.due);
               chk("mant", int'(bus.oMant), cur.mant);
               chk("exp",  int'(bus.oExp),  cur.exp);
               chk("ovf",  int'(bus.oOvf),  cur.ovf);
               chk("unf",  int'(bus.oUnf),  cur.unf);
            end
         end else if (bus.oValid && have) begin
            chk("hold_mant",  int'(bus.oMant),  cur.mant);
            chk("hold_exp",   int'(bus.oExp),   cur.exp);
            chk("hold_flags", int'({bus.oOvf, bus.oUnf}), cur.ovf * 2 + cur.unf);
            chk("hold_ready", int'(bus.oReady), 0);
         end
         prev = bus.oValid;
      end
   end

   // Issue one product; caller is at a negedge. Garbage follows for one busy cycle.
   task automatic send(input logic [14:0] m, input logic [4:0] e);
      int n = 0;
      while (!bus.oReady) begin
         @(negedge clkNorm);
         n++;
         if (n > 100) begin
            chk("ready_timeout", 0, 1);
            return;
         end
      end
      bus.iValid = 1'b1;
      bus.iMantP = m;
      bus.iExpP  = e;
      sb.push_back(model(m, e, cyc + 1));
      @(negedge clkNorm);
      bus.iMantP = 15'($urandom);
      bus.iExpP  = 5'($urandom);
      @(negedge clkNorm);
      bus.iValid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 || bus.oValid) begin
         @(negedge clkNorm);
         n++;
         if (n > 200) begin
            chk("drain_timeout", 0, 1);
            return;
         end
      end
   endtask

   initial begin
      int n;
      bus.iValid = 1'b0;
      bus.iMantP = '0;
      bus.iExpP  = '0;
      iReset_n   = 1'b0;
      #12;
      chk("rst_ready", int'(bus.oReady), 1);
      chk("rst_valid", int'(bus.oValid), 0);
      chk("rst_mant",  int'(bus.oMant),  0);
      chk("rst_exp",   int'(bus.oExp),   0);
      chk("rst_flags", int'({bus.oOvf, bus.oUnf}), 0);
      @(negedge clkNorm);
      iReset_n = 1'b1;

      // Directed corner cases, first one issued right after reset release
      send(15'h4000, 5'd0);
      send(15'h0001, 5'd0);
      send(15'h7FF0, 5'd0);
      send(15'h4000, 5'b01111);
      send(15'h0001, 5'b10000);
      send(15'h0000, 5'b01010);
      send(15'h7FFF, 5'b01111);
      send(15'h0200, 5'b10000);
      drain();

      // Backpressure: hold result 5 cycles while a new product is offered
      bp_force = 1'b1;
      send(15'h4000, 5'd0);
      n = 0;
      while (!bus.oValid && n < 40) begin @(negedge clkNorm); n++; end
      chk("bp_valid_seen", int'(bus.oValid), 1);
      for (int i = 0; i < 5; i++) begin
         bus.iValid = 1'b1;
         bus.iMantP = 15'h0123;
         bus.iExpP  = 5'b00011;
         @(negedge clkNorm);
      end
      bus.iValid = 1'b0;
      bp_force   = 1'b0;
      drain();

      // Reset in the middle of a long shift: word must vanish
      send(15'h0001, 5'd0);
      repeat (4) @(negedge clkNorm);
      #2 iReset_n = 1'b0;
      #1;
      chk("midrst_valid", int'(bus.oValid), 0);
      chk("midrst_ready", int'(bus.oReady), 1);
      sb.delete();
      @(negedge clkNorm);
      iReset_n = 1'b1;
      repeat (20) @(negedge clkNorm);
      chk("midrst_no_output", int'(bus.oValid), 0);

      // Random products with varied leading-zero counts
      for (int i = 0; i < 200; i++) begin
         logic [14:0] m;
         m = 15'($urandom) >> $urandom_range(0, 14);
         send(m, 5'($urandom));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/product_normalizer.md
PRODUCT_NORMALIZER -- requirements
Module: product_normalizer

Interface
REQ-001: Parameters: none; all widths are fixed (15-bit product mantissa in, 10-bit mantissa out, 5-bit exponents).
REQ-002: The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-003: clkNorm  input  1  single clock; all state updates on the rising edge.
REQ-004: iReset_n  input  1  asynchronous active-low reset.
REQ-005: iValid  input  1  product word present on iMantP/iExpP.
REQ-006: oReady  output  1  block can accept a product this cycle.
REQ-007: iMantP  input  15  unsigned product mantissa M from float_multiplier (oMantR).
REQ-008: iExpP  input  5  two's-complement exponent E from float_multiplier (oExpR); value = M x 2^E.
REQ-009: oValid  output  1  normalized result present.
REQ-010: iReady  input  1  downstream accepts the result.
REQ-011: oMant  output  10  normalized mantissa; bit 9 set unless the result is zero.
REQ-012: oExp  output  5  two's-complement result exponent; value = oMant x 2^oExp.
REQ-013: oOvf  output  1  saturated on exponent overflow; valid with oValid.
REQ-014: oUnf  output  1  flushed to zero on exponent underflow; valid with oValid.

Function
REQ-015: The FSM SHALL have states IDLE, SHIFT, ROUND and DONE; oReady = 1 only in IDLE.
REQ-016: Accept: in IDLE with iValid=1, the block SHALL capture M into a 15-bit work register W and E into a 7-bit signed counter X, and go to SHIFT; iValid=0 SHALL leave it in IDLE.
REQ-017: SHIFT with W[14]=0 and W!=0: the block SHALL shift W left by 1 and decrement X by 1 (one bit per cycle).
REQ-018: SHIFT with W[14]=1 or W=0: the block SHALL go to ROUND.
REQ-019: ROUND: t = W[14:5] + W[4] (round half up); Eo = X + 5.
REQ-020: Rounding carry: if t = 1024, the block SHALL use mantissa 10'h200 and Eo + 1.
REQ-021: ROUND SHALL register oMant/oExp/flags and go to DONE, with oValid = 1 in DONE only.
REQ-022: Zero (W=0): oMant=0, oExp=0, oOvf=0, oUnf=0.
REQ-023: Overflow (Eo > 15, signed): oMant=10'h3FF, oExp=5'b01111, oOvf=1.
REQ-024: Underflow (Eo < -16): oMant=0, oExp=0, oUnf=1.
REQ-025: Latency: with s = number of leading zeros of M within 15 bits (0..14; 0 for M=0), oValid SHALL rise s+2 edges after the accepting edge; range 2..16 cycles.
REQ-026: DONE SHALL hold oValid and all outputs stable while iReady=0; DONE with iReady=1 SHALL return to IDLE on the next edge.
REQ-027: Inputs presented while oReady=0 SHALL be ignored and SHALL NOT disturb W, X or the outputs.
REQ-028: Internal exponent arithmetic SHALL be 7-bit signed with no wrap-around; the range check SHALL occur before truncation to 5 bits.

Reset
REQ-029: On iReset_n=0, asynchronously and including mid-operation: state=IDLE, oReady=1, oValid=0, oMant=0, oExp=0, oOvf=0, oUnf=0, W=0, X=0.
REQ-030: The first accept SHALL be possible on the first rising edge after iReset_n deasserts.
REQ-031: A partially normalized word in flight at reset SHALL be discarded and SHALL never appear on the outputs.

Verification
REQ-032: iMantP=15'h4000, iExpP=0 -> after 2 cycles oMant=10'h200, oExp=5'b00101, flags 0.
REQ-033: iMantP=15'h0001, iExpP=0 -> after 16 cycles oMant=10'h200, oExp=5'b10111 (-9).
REQ-034: iMantP=15'h7FF0, iExpP=0 -> rounding carry: oMant=10'h200, oExp=5'b00110.
REQ-035: iMantP=15'h4000, iExpP=5'b01111 -> oMant=10'h3FF, oExp=5'b01111, oOvf=1.
REQ-036: iMantP=15'h0001, iExpP=5'b10000 -> oMant=0, oExp=0, oUnf=1.
REQ-037: Backpressure and reset:
- iReady held 0 for 5 cycles in DONE -> outputs stable and oReady=0 throughout; a new iValid is ignored.
- iReset_n pulsed low mid-SHIFT -> immediately IDLE, oValid=0.
